timer_scheduler: RTL and testbench
==================================

// Module: timer_scheduler
// PURPOSE
//  Shared timer resource: one prescaler plus one time-multiplexed decrementer serve
//  CHANNELS independent software timers (periodic or one-shot), replacing one
//  32-bit counter per timer. Sits between the 50 MHz system clock domain and LED/FSM
//  consumers; each channel emits a one-cycle elapsed event, same semantics as a timer.
// PARAMETERS
//  CHANNELS     4       number of timer channels (2..16)
//  TICK_DIV     50000   clock cycles per scheduler tick (1 kHz at 50 MHz); must be >= CHANNELS+2
//  COUNT_WIDTH  16      width of per-channel period/count, in ticks
// PORTS
//  clock        in   1                  50 MHz system clock
//  reset        in   1                  synchronous, active-high reset
//  cfg_write    in   1                  write cfg_period/cfg_oneshot into channel cfg_channel
//  cfg_channel  in   $clog2(CHANNELS)   channel index for cfg_write
//  cfg_period   in   COUNT_WIDTH        period in ticks (0 = channel disabled)
//  cfg_oneshot  in   1                  1 = one-shot, 0 = periodic
//  start        in   CHANNELS           per-channel start/restart pulse
//  stop         in   CHANNELS           per-channel stop pulse
//  running      out  CHANNELS           channel is counting
//  elapsed      out  CHANNELS           one-cycle pulse when channel period expires
//  tick         out  1                  one-cycle prescaler tick (debug/observability)
// BEHAVIOUR
//  Reset (sync, on clock edge with reset=1): prescaler=0, tick=0, state=IDLE, scan index=0;
//   every channel period=0, oneshot=0, count=0; running=0, elapsed=0. Overrides all inputs.
//   Reset mid-scan aborts the scan; no elapsed pulse is produced for that tick.
//  Prescaler: counts 0..TICK_DIV-1 and wraps; tick registered, high exactly one cycle
//   after the cycle in which prescaler==TICK_DIV-1. Runs regardless of channel state.
//  FSM: IDLE -> SCAN when tick=1 (idx<=0). SCAN services channel idx, idx++;
//   SCAN -> IDLE after idx==CHANNELS-1. Never more than one scan per tick (TICK_DIV check).
//  Service of channel k (SCAN, idx==k), if running[k]:
//   count==1: elapsed[k]<=1 next cycle; periodic -> count<=period; one-shot -> running<=0.
//   else count<=count-1. Non-running channel: untouched.
//  Latency: tick high in cycle T -> elapsed[k] high in cycle T+2+k. First elapsed after
//   start occurs on the period-th tick serviced after start takes effect.
//  Start[k]: if effective period!=0 -> count<=period, running<=1 (restart if running).
//   Effective period = cfg_period if cfg_write targets k in same cycle, else stored period.
//   Period 0: start ignored, running stays 0.
//  Stop[k]: running<=0; count retained but irrelevant. start&stop same cycle: stop wins.
//  Start/stop on channel k in the same cycle it is serviced: start/stop wins, no decrement,
//   no elapsed pulse for that service.
//  cfg_write to running channel: period/mode stored, current count unaffected; new period
//   applies at next reload. Writing period 0 to running channel: finishes current period,
//   then stops (periodic reload of 0 -> running<=0), elapsed still pulses once.
//  elapsed: registered, all bits 0 except the single pulsed bit; at most one bit high per cycle.
//  Count arithmetic unsigned COUNT_WIDTH; no underflow possible (count>=1 while running).
//  Elaboration: $error if TICK_DIV < CHANNELS+2 or CHANNELS < 2.
// TESTING (bench: CHANNELS=4, TICK_DIV=8, COUNT_WIDTH=8)
//  Reset 3 cycles -> running=0, elapsed=0, tick pulses every 8 cycles from then on.
//  cfg ch0 period=3 periodic, start[0] -> elapsed[0] every 24 cycles, 2+0 cycles after tick.
//  cfg ch2 period=2 one-shot, start[2] -> single elapsed[2] at 2nd tick +4 cycles, running[2]=0 after.
//  ch1 period=0, start[1] -> running[1] stays 0; start[3]&stop[3] same cycle -> running[3]=0.
//  ch0 running period 3, cfg_write period=5 mid-period -> next elapsed at old 3, then every 40 cycles.
//  Assert reset during SCAN with ch1 count=1 -> no elapsed[1], all outputs 0 next cycle.

Source files
------------

// File: rtl/timer_scheduler.sv
// Shared prescaler plus one time-multiplexed decrementer serving CHANNELS software timers.
// Each channel runs periodic or one-shot and emits a one-cycle elapsed pulse on expiry.
module timer_scheduler #(
   parameter int unsigned CHANNELS    = 4,
   parameter int unsigned TICK_DIV    = 50000,
   parameter int unsigned COUNT_WIDTH = 16
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        cfg_write,
   input  logic [$clog2(CHANNELS)-1:0] cfg_channel,
   input  logic [COUNT_WIDTH-1:0]      cfg_period,
   input  logic                        cfg_oneshot,
   input  logic [CHANNELS-1:0]         start,
   input  logic [CHANNELS-1:0]         stop,
   output logic [CHANNELS-1:0]         running,
   output logic [CHANNELS-1:0]         elapsed,
   output logic                        tick
);

   localparam int unsigned IW = $clog2(CHANNELS);
   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   if (CHANNELS < 2 || TICK_DIV < CHANNELS + 2) begin : g_param_check
      $error("timer_scheduler: CHANNELS must be >= 2 and TICK_DIV >= CHANNELS+2");
   end

   typedef enum logic {
      IDLE,
      SCAN
   } state_t;

   state_t                 state_q, state_d;
   logic [IW-1:0]          idx_q, idx_d;
   logic [PW-1:0]          presc_q, presc_d;
   logic                   tick_q, tick_d;
   logic                   svc_valid;

   logic [COUNT_WIDTH-1:0] period_q [CHANNELS];
   logic [COUNT_WIDTH-1:0] period_d [CHANNELS];
   logic [COUNT_WIDTH-1:0] count_q  [CHANNELS];
   logic [COUNT_WIDTH-1:0] count_d  [CHANNELS];
   logic [CHANNELS-1:0]    oneshot_q, oneshot_d;
   logic [CHANNELS-1:0]    running_q, running_d;
   logic [CHANNELS-1:0]    elapsed_q, elapsed_d;

   always_comb begin
      tick_d  = (presc_q == PW'(TICK_DIV - 1));
      presc_d = tick_d ? '0 : presc_q + PW'(1);
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      svc_valid = 1'b0;
      case (state_q)
         IDLE: begin
            if (tick_q) begin
               state_d = SCAN;
               idx_d   = '0;
            end
         end
         SCAN: begin
            svc_valid = 1'b1;
            if (idx_q == IW'(CHANNELS - 1)) begin
               state_d = IDLE;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Priority per channel: stop, then a start with nonzero effective period, then the scan service.
   always_comb begin
      oneshot_d = oneshot_q;
      running_d = running_q;
      elapsed_d = '0;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
         logic                   wr_k;
         logic [COUNT_WIDTH-1:0] eff_period;
         period_d[k] = period_q[k];
         count_d[k]  = count_q[k];
         wr_k        = cfg_write && (cfg_channel == IW'(k));
         eff_period  = wr_k ? cfg_period : period_q[k];
         if (wr_k) begin
            period_d[k]  = cfg_period;
            oneshot_d[k] = cfg_oneshot;
         end
         if (stop[k]) begin
            running_d[k] = 1'b0;
         end else if (start[k] && (eff_period != '0)) begin
            count_d[k]   = eff_period;
            running_d[k] = 1'b1;
         end else if (svc_valid && (idx_q == IW'(k)) && running_q[k]) begin
            if (count_q[k] == COUNT_WIDTH'(1)) begin
               elapsed_d[k] = 1'b1;
               // A stored period of 0 means the channel was disabled while counting.
               if (oneshot_q[k] || (period_q[k] == '0)) begin
                  running_d[k] = 1'b0;
               end else begin
                  count_d[k] = period_q[k];
               end
            end else begin
               count_d[k] = count_q[k] - COUNT_WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         presc_q   <= '0;
         tick_q    <= 1'b0;
         oneshot_q <= '0;
         running_q <= '0;
         elapsed_q <= '0;
         for (int unsigned k = 0; k < CHANNELS; k++) begin
            period_q[k] <= '0;
            count_q[k]  <= '0;
         end
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         presc_q   <= presc_d;
         tick_q    <= tick_d;
         oneshot_q <= oneshot_d;
         running_q <= running_d;
         elapsed_q <= elapsed_d;
         for (int unsigned k = 0; k < CHANNELS; k++) begin
            period_q[k] <= period_d[k];
            count_q[k]  <= count_d[k];
         end
      end
   end

   assign running = running_q;
   assign elapsed = elapsed_q;
   assign tick    = tick_q;

endmodule

// File: tb/tb_timer_scheduler.sv
// Bench for timer_scheduler: directed scenarios then random traffic, checked every cycle
// against a cycle-count based reference model of the timer rules.
module tb_timer_scheduler;

   localparam int CH = 4;
   localparam int TD = 8;
   localparam int CW = 8;

   logic          clock = 1'b0;
   logic          reset;
   logic          cfg_write;
   logic [1:0]    cfg_channel;
   logic [CW-1:0] cfg_period;
   logic          cfg_oneshot;
   logic [CH-1:0] start;
   logic [CH-1:0] stop;
   logic [CH-1:0] running;
   logic [CH-1:0] elapsed;
   logic          tick;

   timer_scheduler #(
      .CHANNELS   (CH),
      .TICK_DIV   (TD),
      .COUNT_WIDTH(CW)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .cfg_write  (cfg_write),
      .cfg_channel(cfg_channel),
      .cfg_period (cfg_period),
      .cfg_oneshot(cfg_oneshot),
      .start      (start),
      .stop       (stop),
      .running    (running),
      .elapsed    (elapsed),
      .tick       (tick)
   );

   always #5 clock = ~clock;

   // Model: m_cyc counts cycles since the last reset edge; ticks land on multiples of TD,
   // and channel k is serviced TD*n + 1 + k cycles after reset.
   int            m_cyc;
   logic [CW-1:0] m_per [CH];
   logic [CW-1:0] m_cnt [CH];
   logic [CH-1:0] m_os;
   logic [CH-1:0] m_run;
   logic [CH-1:0] m_el;
   logic          m_tick;

   int vectors     = 0;
   int miscompares = 0;
   int cyc_abs     = 0;

   task automatic model_edge();
      logic [CH-1:0] el_n;
      logic [CW-1:0] eff;
      int            slot;
      if (reset) begin
         m_cyc  = 0;
         m_run  = '0;
         m_el   = '0;
         m_os   = '0;
         m_tick = 1'b0;
         for (int k = 0; k < CH; k++) begin
            m_per[k] = '0;
            m_cnt[k] = '0;
         end
      end else begin
         el_n = '0;
         slot = -1;
         if (m_cyc >= TD + 1 && (m_cyc % TD) >= 1 && (m_cyc % TD) <= CH)
            slot = (m_cyc % TD) - 1;
         for (int k = 0; k < CH; k++) begin
            eff = (cfg_write && int'(cfg_channel) == k) ? cfg_period : m_per[k];
            if (stop[k]) begin
               m_run[k] = 1'b0;
            end else if (start[k] && eff != '0) begin
               m_cnt[k] = eff;
               m_run[k] = 1'b1;
            end else if (slot == k && m_run[k]) begin
               if (m_cnt[k] == CW'(1)) begin
                  el_n[k] = 1'b1;
                  if (m_os[k] || m_per[k] == '0) m_run[k] = 1'b0;
                  else m_cnt[k] = m_per[k];
               end else begin
                  m_cnt[k] = m_cnt[k] - CW'(1);
               end
            end
            if (cfg_write && int'(cfg_channel) == k) begin
               m_per[k] = cfg_period;
               m_os[k]  = cfg_oneshot;
            end
         end
         m_el   = el_n;
         m_cyc  = m_cyc + 1;
         m_tick = (m_cyc >= TD) && (m_cyc % TD == 0);
      end
   endtask

   task automatic check(input string tag);
      vectors++;
      assert (tick === m_tick) else begin
         miscompares++;
         $error("FAIL %s tick: observed %b expected %b", tag, tick, m_tick);
      end
      vectors++;
      assert (running === m_run) else begin
         miscompares++;
         $error("FAIL %s running: observed %b expected %b", tag, running, m_run);
      end
      vectors++;
      assert (elapsed === m_el) else begin
         miscompares++;
         $error("FAIL %s elapsed: observed %b expected %b", tag, elapsed, m_el);
      end
   endtask

   task automatic step(input string tag);
      model_edge();
      @(posedge clock);
      #1;
      cyc_abs++;
      check(tag);
      cfg_write = 1'b0;
      start     = '0;
      stop      = '0;
   endtask

   task automatic cfg(input int ch, input int per, input logic os);
      cfg_write   = 1'b1;
      cfg_channel = 2'(ch);
      cfg_period  = CW'(per);
      cfg_oneshot = os;
   endtask

   initial begin
      int   last;
      int   w;
      int   t0;
      int   pulses[$];

      reset = 1'b1; cfg_write = 1'b0; cfg_channel = '0; cfg_period = '0;
      cfg_oneshot = 1'b0; start = '0; stop = '0;
      #1;

      // Reset for three cycles
      repeat (3) step("reset");
      reset = 1'b0;

      // ch0 periodic, period 3: pulses 24 cycles apart, two cycles after a tick
      cfg(0, 3, 1'b0);
      step("cfg0");
      start[0] = 1'b1;
      step("start0");
      last = -1;
      repeat (60) begin
         step("periodic0");
         if (elapsed[0]) begin
            vectors++;
            assert ((m_cyc % TD) === 2) else begin
               miscompares++;
               $error("FAIL ch0_phase: observed %0d expected 2", m_cyc % TD);
            end
            if (last >= 0) begin
               vectors++;
               assert ((cyc_abs - last) === 24) else begin
                  miscompares++;
                  $error("FAIL ch0_gap: observed %0d expected 24", cyc_abs - last);
               end
            end
            last = cyc_abs;
         end
      end

      // ch2 one-shot, period 2
      cfg(2, 2, 1'b1);
      step("cfg2");
      start[2] = 1'b1;
      step("start2");
      repeat (40) step("oneshot2");
      vectors++;
      assert (running[2] === 1'b0) else begin
         miscompares++;
         $error("FAIL ch2_done: observed %b expected 0", running[2]);
      end

      // ch1 period 0 start ignored; ch3 start&stop together
      cfg(1, 0, 1'b0);
      start[1] = 1'b1;
      step("start1_p0");
      cfg(3, 4, 1'b0);
      step("cfg3");
      start[3] = 1'b1;
      stop[3]  = 1'b1;
      step("startstop3");
      vectors++;
      assert (running[3] === 1'b0 && running[1] === 1'b0) else begin
         miscompares++;
         $error("FAIL ch1_ch3_idle: observed %b expected 0x0x", running);
      end

      // ch0 period changed 3 -> 5 just after a pulse
      w = 0;
      while (!elapsed[0] && w < 40) begin
         step("wait0");
         w++;
      end
      vectors++;
      assert (elapsed[0] === 1'b1) else begin
         miscompares++;
         $error("FAIL wait_elapsed0: observed %b expected 1", elapsed[0]);
      end
      t0 = cyc_abs;
      cfg(0, 5, 1'b0);
      repeat (110) begin
         step("reperiod0");
         if (elapsed[0]) pulses.push_back(cyc_abs);
      end
      vectors++;
      assert (pulses.size() >= 3) else begin
         miscompares++;
         $error("FAIL reperiod_count: observed %0d expected >=3", pulses.size());
      end
      if (pulses.size() >= 3) begin
         vectors++;
         assert ((pulses[0] - t0) === 24) else begin
            miscompares++;
            $error("FAIL reperiod_gap0: observed %0d expected 24", pulses[0] - t0);
         end
         vectors++;
         assert ((pulses[1] - pulses[0]) === 40 && (pulses[2] - pulses[1]) === 40) else begin
            miscompares++;
            $error("FAIL reperiod_gap: observed %0d,%0d expected 40,40",
                   pulses[1] - pulses[0], pulses[2] - pulses[1]);
         end
      end

      // Reset in the cycle ch1 (count 1) is being serviced
      cfg(1, 1, 1'b0);
      step("cfg1");
      start[1] = 1'b1;
      step("start1");
      w = 0;
      while (!(m_cyc >= TD + 1 && (m_cyc % TD) == 2) && w < 40) begin
         step("wait_scan1");
         w++;
      end
      vectors++;
      assert (running[1] === 1'b1 && (m_cyc % TD) === 2) else begin
         miscompares++;
         $error("FAIL scan1_reached: observed run=%b phase=%0d expected 1/2", running[1], m_cyc % TD);
      end
      reset = 1'b1;
      step("midscan_reset");
      reset = 1'b0;
      vectors++;
      assert (elapsed === '0 && running === '0 && tick === 1'b0) else begin
         miscompares++;
         $error("FAIL midscan_reset: observed e=%b r=%b t=%b expected 0", elapsed, running, tick);
      end
      repeat (10) step("post_reset");

      // Random traffic
      repeat (800) begin
         if ($urandom_range(0, 5) == 0)
            cfg(int'($urandom_range(0, CH - 1)), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
         for (int k = 0; k < CH; k++) begin
            start[k] = ($urandom_range(0, 19) == 0);
            stop[k]  = ($urandom_range(0, 39) == 0);
         end
         reset = ($urandom_range(0, 249) == 0);
         step("random");
      end
      reset = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
